hms_timer_ctrl: RTL
===================

Name: hms_timer_ctrl

Overview:
Parametrised successor of the board countdown timer. It holds an H:M:S value and operates in one of two modes: countdown, or stopwatch (count-up). It supports per-digit editing with correct modulo wrap, a pause that retains the value, and an alarm that auto-clears and reloads the last preset. It sits between the KEY pushbuttons and the HEX/LEDR drivers; its outputs are BCD digits, a per-digit blank mask for cursor blinking, and the alarm level.

Parameters:
CLK_HZ, 50000000, clock cycles per second tick
BLINK_HZ, 1, cursor blink rate in SET; the blank phase toggles every CLK_HZ/(2*BLINK_HZ) cycles
MAX_SECONDS, 86400, modulus of the timer value (legal values 0..MAX_SECONDS-1)
ALARM_SECS, 30, seconds ALARM stays asserted before auto-clear
TW, 17, width of the seconds value (must hold MAX_SECONDS-1)

Ports:
CLOCK_50 in 1 system clock
RESET in 1 asynchronous, active-high reset
KEY in 4 raw active-low buttons: [0]=INC, [1]=DEC, [2]=SEL, [3]=RUN
MODE in 1 0=countdown, 1=stopwatch; sampled only on SET->RUN
SECONDS out TW current timer value
DIGITS out 24 BCD digits {h1,h2,m1,m2,s1,s2}; s2 in [3:0]
BLANK out 6 per-digit blank mask; bit i corresponds to cursor position i
ALARM out 1 alarm active; drives LEDR
STATE out 2 00=SET, 01=RUN, 10=ALARM
CURSOR out 3 edit position 0..5 (0=s2 ... 5=h1)
TICK out 1 one-cycle pulse on each second boundary while in RUN

Behaviour:
- Reset values: SECONDS=MAX_SECONDS-1 (23:59:59); preset register equals the same value; STATE=SET; CURSOR=0; ALARM=0; BLANK=0; TICK=0; all prescalers 0; sync flops 1 (released). DIGITS reflect the reset value after one clock.
- Keys: 2-flop synchroniser per bit, then a registered copy. An event is the press edge (synced=0, previous=1), one cycle wide. The action takes effect on the 3rd rising clock edge after the pin falls. No debounce; the bench drives clean edges.
- Key priority within one cycle: RUN > SEL > INC > DEC. Lower-priority events in the same cycle are dropped.
- Step size by CURSOR: 1, 10, 60, 600, 3600, 36000. CURSOR values 6 and 7 are unreachable.
- SET state:
  - INC: t = t+step, minus MAX_SECONDS if the sum is >= MAX_SECONDS.
  - DEC: t = t-step if t >= step, else t+MAX_SECONDS-step. There is no unsigned underflow.
  - SEL: CURSOR = (CURSOR+1) mod 6.
  - RUN: latch MODE and copy t to preset. Countdown with t==0: ignored, stays in SET. Otherwise go to RUN with the second prescaler cleared.
  - Blink: the phase counter runs; BLANK[CURSOR] = phase, all other bits 0.
- RUN state:
  - BLANK=0. The prescaler counts 0..CLK_HZ-1; the wrap cycle asserts TICK. The first TICK occurs exactly CLK_HZ cycles after RUN is entered.
  - Countdown: on TICK, t = t-1. If the result is 0, go to ALARM in the same cycle (ALARM=1 on the next cycle).
  - Stopwatch: on TICK, t = t+1, wrapping MAX_SECONDS-1 -> 0. It never alarms.
  - RUN key: go to SET, keeping t (pause). The prescaler is cleared. Other keys are ignored.
  - A MODE change during RUN has no effect.
- ALARM state:
  - ALARM=1 and t=0. The prescaler keeps running and an alarm-second counter counts ticks (TICK output stays 0).
  - A RUN press, or ALARM_SECS elapsed seconds, returns to SET with t=preset and ALARM=0.
- DIGITS: combinational split of t (s2=t%10, s1=(t/10)%6, m2=(t/60)%10, m1=(t/600)%6, h2=(t/3600)%10, h1=t/36000), then registered. DIGITS lags SECONDS by exactly 1 cycle.
- A RESET assertion at any time (mid-RUN, mid-ALARM) returns immediately to the reset values. A key held through reset produces no event after release of reset.

Decomposition:
- Shared package hms_timer_pkg holds:
  - state encodings ST_SET, ST_RUN, ST_ALARM;
  - key indices K_INC, K_DEC, K_SEL, K_RUN;
  - a 6-entry step constant table;
  - cursor count 6.
- One sub-module: hms_to_bcd (combinational, TW in, 24-bit BCD out), reusable by other display blocks. The registering of DIGITS stays in the parent.

Test Plan:
Use CLK_HZ=10, BLINK_HZ=1, ALARM_SECS=3 in simulation.
1. Reset: after release, SET, SECONDS=86399 and DIGITS=0x235959. Press INC -> SECONDS=0, DIGITS=0x000000.
2. Edit wrap: from 0, CURSOR=0, press DEC -> 86399. Press SEL x5 (CURSOR=5), press INC -> 86399+36000-86400=35999. Press SEL once more -> CURSOR=0.
3. Countdown: set t=2, MODE=0, press RUN.
   - TICK occurs 10 cycles after entry and gives t=1.
   - 10 cycles later t=0 and ALARM=1.
   - After 3x10 cycles, SET with t=2 and ALARM=0.
4. Pause and zero start:
   - In RUN at t=5, press RUN -> SET with t=5 held, and BLANK[0] toggles every 5 cycles.
   - Setting t=0 and pressing RUN with MODE=0 stays in SET.
5. Stopwatch: t=86398, MODE=1, RUN. Two ticks give 86399 then 0; ALARM never asserts. A MODE toggle mid-run has no effect.
6. Priority and reset:
   - INC and SEL pressed in the same cycle in SET -> only CURSOR advances.
   - RESET pulse during ALARM -> ALARM=0 asynchronously, SET, SECONDS=86399.

Source files
------------

// File: rtl/hms_timer_pkg.sv
// Shared definitions for the H:M:S timer: state encodings, key indices and
// the per-cursor edit step table.
package hms_timer_pkg;

    typedef enum logic [1:0] {
        ST_SET   = 2'b00,
        ST_RUN   = 2'b01,
        ST_ALARM = 2'b10
    } state_t;

    localparam int K_INC = 0;
    localparam int K_DEC = 1;
    localparam int K_SEL = 2;
    localparam int K_RUN = 3;

    localparam int CURSOR_COUNT = 6;

    localparam logic [31:0] STEP_TABLE [0:5] = '{32'd1, 32'd10, 32'd60, 32'd600, 32'd3600, 32'd36000};

    // Positions 6 and 7 cannot be reached; they fall back to the unit step.
    function automatic logic [31:0] step_of(input logic [2:0] cursor);
        logic [31:0] step;
        case (cursor)
            3'd0:    step = STEP_TABLE[0];
            3'd1:    step = STEP_TABLE[1];
            3'd2:    step = STEP_TABLE[2];
            3'd3:    step = STEP_TABLE[3];
            3'd4:    step = STEP_TABLE[4];
            3'd5:    step = STEP_TABLE[5];
            default: step = STEP_TABLE[0];
        endcase
        return step;
    endfunction

endpackage

// File: rtl/hms_to_bcd.sv
// Combinational split of a seconds count into six BCD digits {h1,h2,m1,m2,s1,s2}.
module hms_to_bcd #(
    parameter int TW = 17
) (
    input  logic [TW-1:0] t,
    output logic [23:0]   bcd
);

    logic [31:0] t_s;

    assign t_s         = 32'(t);
    assign bcd[3:0]    = 4'(t_s % 32'd10);
    assign bcd[7:4]    = 4'((t_s / 32'd10) % 32'd6);
    assign bcd[11:8]   = 4'((t_s / 32'd60) % 32'd10);
    assign bcd[15:12]  = 4'((t_s / 32'd600) % 32'd6);
    assign bcd[19:16]  = 4'((t_s / 32'd3600) % 32'd10);
    assign bcd[23:20]  = 4'(t_s / 32'd36000);

endmodule

// File: rtl/hms_timer_ctrl.sv
// H:M:S countdown / stopwatch controller with per-digit editing, pause,
// auto-clearing alarm, cursor blink mask and registered BCD display digits.
module hms_timer_ctrl
    import hms_timer_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int BLINK_HZ    = 1,
    parameter int MAX_SECONDS = 86400,
    parameter int ALARM_SECS  = 30,
    parameter int TW          = 17
) (
    input  logic          CLOCK_50,
    input  logic          RESET,
    input  logic [3:0]    KEY,
    input  logic          MODE,
    output logic [TW-1:0] SECONDS,
    output logic [23:0]   DIGITS,
    output logic [5:0]    BLANK,
    output logic          ALARM,
    output logic [1:0]    STATE,
    output logic [2:0]    CURSOR,
    output logic          TICK
);

    localparam int PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int HALF_RAW = CLK_HZ / (2 * BLINK_HZ);
    localparam int HALF     = (HALF_RAW > 0) ? HALF_RAW : 1;
    localparam int BW       = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int AW       = $clog2(ALARM_SECS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(HALF - 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECS - 1);
    localparam logic [31:0]   MAX_S      = 32'(MAX_SECONDS);
    localparam logic [TW-1:0] T_MAX      = TW'(MAX_SECONDS - 1);

    logic [3:0]    sync1_r, sync2_r, prev_r, ev_s;
    logic [1:0]    flush_r;
    logic          run_ev_s, sel_ev_s, inc_ev_s, dec_ev_s;
    state_t        state_r, state_nxt_s;
    logic [TW-1:0] t_r, t_nxt_s, preset_r, preset_nxt_s;
    logic [2:0]    cursor_r, cursor_nxt_s, cursor_inc_s;
    logic          mode_r, mode_nxt_s;
    logic [PW-1:0] presc_r, presc_nxt_s, presc_inc_s;
    logic          wrap_s, tick_s;
    logic [AW-1:0] acnt_r, acnt_nxt_s;
    logic [BW-1:0] blink_r, blink_nxt_s;
    logic          phase_r, phase_nxt_s;
    logic [31:0]   t_ext_s, step_s, sum_s, inc_val_s, dec_val_s;
    logic          tick_r, alarm_r;
    logic [5:0]    blank_r;
    logic [23:0]   bcd_s, digits_r;

    // Key synchroniser; prev only arms once the chain holds real pin samples,
    // so a key held through reset never looks like a fresh press.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sync1_r <= 4'hF;
            sync2_r <= 4'hF;
            prev_r  <= 4'h0;
            flush_r <= 2'b00;
        end else begin
            sync1_r <= KEY;
            sync2_r <= sync1_r;
            flush_r <= {flush_r[0], 1'b1};
            prev_r  <= sync2_r & {4{flush_r[1]}};
        end
    end

    assign ev_s     = ~sync2_r & prev_r;
    assign run_ev_s = ev_s[K_RUN];
    assign sel_ev_s = ev_s[K_SEL] & ~run_ev_s;
    assign inc_ev_s = ev_s[K_INC] & ~run_ev_s & ~ev_s[K_SEL];
    assign dec_ev_s = ev_s[K_DEC] & ~run_ev_s & ~ev_s[K_SEL] & ~ev_s[K_INC];

    assign t_ext_s      = 32'(t_r);
    assign step_s       = step_of(cursor_r);
    assign sum_s        = t_ext_s + step_s;
    assign inc_val_s    = (sum_s >= MAX_S) ? (sum_s - MAX_S) : sum_s;
    assign dec_val_s    = (t_ext_s >= step_s) ? (t_ext_s - step_s) : (t_ext_s + MAX_S - step_s);
    assign cursor_inc_s = (cursor_r == 3'(CURSOR_COUNT - 1)) ? 3'd0 : (cursor_r + 3'd1);
    assign wrap_s       = (presc_r == PRESC_LAST);
    assign presc_inc_s  = wrap_s ? {PW{1'b0}} : (presc_r + PW'(1));

    // Next-state, timer value and prescaler decisions for SET / RUN / ALARM.
    always_comb begin
        state_nxt_s  = state_r;
        t_nxt_s      = t_r;
        preset_nxt_s = preset_r;
        cursor_nxt_s = cursor_r;
        mode_nxt_s   = mode_r;
        presc_nxt_s  = presc_r;
        acnt_nxt_s   = acnt_r;
        tick_s       = 1'b0;
        case (state_r)
            ST_SET: begin
                presc_nxt_s = {PW{1'b0}};
                acnt_nxt_s  = {AW{1'b0}};
                if (run_ev_s) begin
                    if (!MODE && (t_r == {TW{1'b0}})) begin
                        state_nxt_s = ST_SET;
                    end else begin
                        state_nxt_s  = ST_RUN;
                        mode_nxt_s   = MODE;
                        preset_nxt_s = t_r;
                    end
                end else if (sel_ev_s) begin
                    cursor_nxt_s = cursor_inc_s;
                end else if (inc_ev_s) begin
                    t_nxt_s = TW'(inc_val_s);
                end else if (dec_ev_s) begin
                    t_nxt_s = TW'(dec_val_s);
                end else begin
                    state_nxt_s = ST_SET;
                end
            end
            ST_RUN: begin
                acnt_nxt_s = {AW{1'b0}};
                if (run_ev_s) begin
                    state_nxt_s = ST_SET;
                    presc_nxt_s = {PW{1'b0}};
                end else begin
                    presc_nxt_s = presc_inc_s;
                    if (wrap_s) begin
                        tick_s = 1'b1;
                        if (mode_r) begin
                            t_nxt_s = (t_r == T_MAX) ? {TW{1'b0}} : (t_r + TW'(1));
                        end else begin
                            t_nxt_s     = t_r - TW'(1);
                            state_nxt_s = (t_r == TW'(1)) ? ST_ALARM : ST_RUN;
                        end
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
            end
            ST_ALARM: begin
                t_nxt_s = {TW{1'b0}};
                if (run_ev_s) begin
                    state_nxt_s = ST_SET;
                    t_nxt_s     = preset_r;
                    presc_nxt_s = {PW{1'b0}};
                    acnt_nxt_s  = {AW{1'b0}};
                end else begin
                    presc_nxt_s = presc_inc_s;
                    if (wrap_s && (acnt_r == ALARM_LAST)) begin
                        state_nxt_s = ST_SET;
                        t_nxt_s     = preset_r;
                        presc_nxt_s = {PW{1'b0}};
                        acnt_nxt_s  = {AW{1'b0}};
                    end else if (wrap_s) begin
                        acnt_nxt_s = acnt_r + AW'(1);
                    end else begin
                        acnt_nxt_s = acnt_r;
                    end
                end
            end
            default: begin
                state_nxt_s = ST_SET;
            end
        endcase
    end

    // Cursor blink phase: runs only while staying in SET, restarts otherwise.
    always_comb begin
        if ((state_r == ST_SET) && (state_nxt_s == ST_SET)) begin
            if (blink_r == BLINK_LAST) begin
                blink_nxt_s = {BW{1'b0}};
                phase_nxt_s = ~phase_r;
            end else begin
                blink_nxt_s = blink_r + BW'(1);
                phase_nxt_s = phase_r;
            end
        end else begin
            blink_nxt_s = {BW{1'b0}};
            phase_nxt_s = 1'b0;
        end
    end

    hms_to_bcd #(.TW(TW)) u_bcd (
        .t   (t_r),
        .bcd (bcd_s)
    );

    // Controller state and registered outputs.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_r  <= ST_SET;
            t_r      <= T_MAX;
            preset_r <= T_MAX;
            cursor_r <= 3'd0;
            mode_r   <= 1'b0;
            presc_r  <= {PW{1'b0}};
            acnt_r   <= {AW{1'b0}};
            blink_r  <= {BW{1'b0}};
            phase_r  <= 1'b0;
            tick_r   <= 1'b0;
            alarm_r  <= 1'b0;
            blank_r  <= 6'b000000;
            digits_r <= 24'h000000;
        end else begin
            state_r  <= state_nxt_s;
            t_r      <= t_nxt_s;
            preset_r <= preset_nxt_s;
            cursor_r <= cursor_nxt_s;
            mode_r   <= mode_nxt_s;
            presc_r  <= presc_nxt_s;
            acnt_r   <= acnt_nxt_s;
            blink_r  <= blink_nxt_s;
            phase_r  <= phase_nxt_s;
            tick_r   <= tick_s;
            alarm_r  <= (state_nxt_s == ST_ALARM);
            blank_r  <= ((state_nxt_s == ST_SET) && phase_nxt_s) ? (6'b000001 << cursor_nxt_s) : 6'b000000;
            digits_r <= bcd_s;
        end
    end

    assign SECONDS = t_r;
    assign DIGITS  = digits_r;
    assign BLANK   = blank_r;
    assign ALARM   = alarm_r;
    assign STATE   = state_r;
    assign CURSOR  = cursor_r;
    assign TICK    = tick_r;

endmodule
